unary_stream_encoder: RTL and testbench

- Converts a binary count into a serial unary bitstream of exactly INPUT_WIDTH bits, one bit per accepted cycle.
- Sits directly upstream of the unary adder. bit_out drives one adder operand (a or b); bit_valid drives the matching ready bit.
- Ones are spread evenly using a Bresenham-style accumulator. Every prefix is therefore a tight estimate of the final value, which is what the adder's progressive-bounds logic relies on.

---
 rtl/unary_stream_encoder.sv | 97 +++++++++
 tb/tb_unary_stream_encoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/unary_stream_encoder.sv
// Serialises a binary count into an evenly spread unary bitstream of INPUT_WIDTH bits.
// Each prefix of the stream holds floor(k*val/INPUT_WIDTH) ones.
module unary_stream_encoder #(
    parameter int INPUT_WIDTH = 32,
    parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COUNT_WIDTH-1:0] value_in,
    input  logic                   load,
    input  logic                   stall,
    output logic                   busy,
    output logic                   bit_out,
    output logic                   bit_valid,
    output logic                   done
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam int ACC_WIDTH = COUNT_WIDTH + 1;
    localparam logic [COUNT_WIDTH-1:0] MAX_VAL   = COUNT_WIDTH'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] LAST_IDX  = COUNT_WIDTH'(INPUT_WIDTH - 1);
    localparam logic [ACC_WIDTH-1:0]   WIDTH_EXT = ACC_WIDTH'(INPUT_WIDTH);

    state_t                 state;
    logic [COUNT_WIDTH-1:0] val;
    logic [ACC_WIDTH-1:0]   acc;
    logic [COUNT_WIDTH-1:0] emit_cnt;

    logic [COUNT_WIDTH-1:0] sat_val;
    logic [ACC_WIDTH-1:0]   sum;
    logic                   hit;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic                   last_bit;

    // The extra accumulator bit keeps acc + val exact, so the threshold
    // compare never sees a wrapped sum.
    always_comb begin
        sat_val  = (value_in > MAX_VAL) ? MAX_VAL : value_in;
        sum      = acc + {1'b0, val};
        hit      = (sum >= WIDTH_EXT);
        acc_next = hit ? (sum - WIDTH_EXT) : sum;
        last_bit = (emit_cnt == LAST_IDX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            val       <= '0;
            acc       <= '0;
            emit_cnt  <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_out   <= 1'b0;
                    bit_valid <= 1'b0;
                    done      <= 1'b0;
                    if (load) begin
                        val      <= sat_val;
                        acc      <= '0;
                        emit_cnt <= '0;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (stall) begin
                        bit_out   <= 1'b0;
                        bit_valid <= 1'b0;
                        done      <= 1'b0;
                    end else begin
                        bit_out   <= hit;
                        acc       <= acc_next;
                        bit_valid <= 1'b1;
                        emit_cnt  <= emit_cnt + 1'b1;
                        done      <= last_bit;
                        // Leaving on the final bit lets a load in the done cycle be accepted.
                        if (last_bit) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == STREAM);

endmodule

// File: tb/tb_unary_stream_encoder.sv
// Directed, table-driven bench for unary_stream_encoder with hand-computed
// stream statistics and a floor(k*val/W) prefix model.
module tb_unary_stream_encoder;

    localparam int W  = 32;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          reset;
    logic [CW-1:0] value_in;
    logic          load;
    logic          stall;
    logic          busy;
    logic          bit_out;
    logic          bit_valid;
    logic          done;

    int n_compared;
    int n_failed;

    typedef struct {
        int value;
        int stall_every;
        int load_pulse_at;
        int exp_ones;
        int exp_ones_13;
        int exp_first_one;
    } vec_t;

    vec_t vecs[6];

    unary_stream_encoder #(
        .INPUT_WIDTH(W),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value_in  (value_in),
        .load      (load),
        .stall     (stall),
        .busy      (busy),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic l, input int v, input logic s);
        load     = l;
        value_in = CW'(v);
        stall    = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startLoad(input int v, input logic with_stall);
        applyStimulus(1'b1, v, with_stall);
        tick();
        checkOutput("load_busy", int'(busy), 1);
        checkOutput("load_valid_low", int'(bit_valid), 0);
        applyStimulus(1'b0, 0, 1'b0);
    endtask

    // Runs one stream to completion, checking every bit against the prefix model.
    task automatic streamBits(input int v, input int stall_every, input int load_pulse_at,
                              input int next_load, output int ones, output int ones_13,
                              output int first_one);
        int eff;
        int nbits;
        int cyc;
        int exp_bit;
        logic stalled;
        logic hold_next;
        eff       = (v > W) ? W : v;
        nbits     = 0;
        cyc       = 0;
        ones      = 0;
        ones_13   = 0;
        first_one = 0;
        while (nbits < W && cyc < 200) begin
            stalled   = (stall_every > 0) && ((cyc % stall_every) == stall_every - 1);
            hold_next = (next_load >= 0) && (nbits == W - 1);
            applyStimulus((cyc == load_pulse_at) || hold_next, hold_next ? next_load : 3, stalled);
            tick();
            cyc++;
            if (stalled) begin
                checkOutput("stall_valid", int'(bit_valid), 0);
                checkOutput("stall_done", int'(done), 0);
            end else begin
                nbits++;
                exp_bit = (nbits * eff) / W - ((nbits - 1) * eff) / W;
                checkOutput("bit_valid", int'(bit_valid), 1);
                checkOutput("bit_out", int'(bit_out), exp_bit);
                checkOutput("done", int'(done), (nbits == W) ? 1 : 0);
                checkOutput("busy", int'(busy), (nbits == W) ? 0 : 1);
                if (bit_out) begin
                    ones++;
                    if (first_one == 0) first_one = nbits;
                end
                if (nbits == 13) ones_13 = ones;
            end
        end
        if (nbits < W) checkOutput("stream_timeout", nbits, W);
        if (next_load < 0) applyStimulus(1'b0, 0, 1'b0);
    endtask

    initial begin
        int ones;
        int ones_13;
        int first_one;

        n_compared = 0;
        n_failed   = 0;

        vecs[0] = '{value: 16, stall_every: 0, load_pulse_at: 5,  exp_ones: 16, exp_ones_13: 6,  exp_first_one: 2};
        vecs[1] = '{value: 0,  stall_every: 0, load_pulse_at: -1, exp_ones: 0,  exp_ones_13: 0,  exp_first_one: 0};
        vecs[2] = '{value: 32, stall_every: 0, load_pulse_at: -1, exp_ones: 32, exp_ones_13: 13, exp_first_one: 1};
        vecs[3] = '{value: 40, stall_every: 0, load_pulse_at: -1, exp_ones: 32, exp_ones_13: 13, exp_first_one: 1};
        vecs[4] = '{value: 5,  stall_every: 0, load_pulse_at: -1, exp_ones: 5,  exp_ones_13: 2,  exp_first_one: 7};
        vecs[5] = '{value: 16, stall_every: 3, load_pulse_at: -1, exp_ones: 16, exp_ones_13: 6,  exp_first_one: 2};

        reset = 1'b0;
        applyStimulus(1'b0, 0, 1'b0);
        #12;
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_valid", int'(bit_valid), 0);
        checkOutput("reset_bit", int'(bit_out), 0);
        checkOutput("reset_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        checkOutput("idle_busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d: value %0d stall_every %0d", i, vecs[i].value, vecs[i].stall_every);
            startLoad(vecs[i].value, 1'b0);
            streamBits(vecs[i].value, vecs[i].stall_every, vecs[i].load_pulse_at, -1,
                       ones, ones_13, first_one);
            checkOutput("total_ones", ones, vecs[i].exp_ones);
            checkOutput("ones_at_13", ones_13, vecs[i].exp_ones_13);
            checkOutput("first_one", first_one, vecs[i].exp_first_one);
            tick();
            checkOutput("post_idle_valid", int'(bit_valid), 0);
            checkOutput("post_idle_done", int'(done), 0);
        end

        // Back-to-back: load+stall accepted in IDLE, then load held through the done cycle.
        $display("[TB] back-to-back streams");
        startLoad(5, 1'b1);
        streamBits(5, 0, -1, 32, ones, ones_13, first_one);
        checkOutput("b2b_first_ones", ones, 5);
        tick();
        checkOutput("b2b_busy", int'(busy), 1);
        checkOutput("b2b_done_low", int'(done), 0);
        applyStimulus(1'b0, 0, 1'b0);
        streamBits(32, 0, -1, -1, ones, ones_13, first_one);
        checkOutput("b2b_second_ones", ones, 32);
        tick();

        // Asynchronous reset in the middle of a stream.
        $display("[TB] mid-stream reset");
        startLoad(16, 1'b0);
        for (int k = 0; k < 10; k++) tick();
        checkOutput("pre_reset_busy", int'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_reset_busy", int'(busy), 0);
        checkOutput("mid_reset_valid", int'(bit_valid), 0);
        checkOutput("mid_reset_bit", int'(bit_out), 0);
        checkOutput("mid_reset_done", int'(done), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("held_reset_done", int'(done), 0);
            checkOutput("held_reset_valid", int'(bit_valid), 0);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checkOutput("after_reset_busy", int'(busy), 0);
        startLoad(16, 1'b0);
        streamBits(16, 0, -1, -1, ones, ones_13, first_one);
        checkOutput("after_reset_ones", ones, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
